debug_run_controller: RTL
=========================

# debug_run_controller

APB master that sequences the debugger status register on behalf of a host command port. It turns single host commands (halt, resume, step N instructions, reset CPU) into correctly ordered status-register read/write/poll transactions, then reports completion, error and final status. It sits between the host link (UART/JTAG front end) and the status register's APB slave port.

## Interface
- `STATUS_ADDR`, default 5'h00: PADDR used for every transfer.
- `POLL_LIMIT`, default 255: maximum status reads per poll phase before timeout (1..255).
- `STEP_GAP`, default 8: idle cycles after each step write before polling starts (must be ≥8).

Ports:
- `PCLK`  in  1  clock.
- `PRESET`  in  1  reset. Synchronous, active-high.
- `cmd_valid`  in  1  host command valid.
- `cmd_ready`  out  1  controller idle and accepting.
- `cmd_op`  in  2  0=HALT, 1=RESUME, 2=STEP, 3=RESET_CPU.
- `cmd_count`  in  8  step count; STEP only.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_error`  out  1  qualified by rsp_valid: timeout or illegal STEP.
- `rsp_status`  out  8  last PRDATA captured; held until next command.
- `rsp_steps`  out  8  steps completed; held until next command.
- `PSEL`, `PENABLE`, `PWRITE`  out  1  APB master controls.
- `PADDR`  out  5  always STATUS_ADDR.
- `PWDATA`  out  8  write data.
- `PRDATA`  in  8  bit0 DEBUG_REQUEST, bit1 DEBUG_ACK, bit2 RESET_REQUEST, bit3 HALTED.
- `PREADY`  in  1  slave ready.

## Operation
- Status-register write semantics: bit0=1 toggles debug request; bit2=1 starts reset pulse; bit4=1 starts step window (debug request masked ~7 cycles).
- States: IDLE, SETUP, ACCESS, GAP, DECIDE, WAIT, DONE.
- IDLE: cmd_ready=1. Handshake on cmd_valid&cmd_ready latches op/count and clears rsp_status/rsp_steps.
- Every command begins with one status read. Then:
  - HALT: bit0=0 → write 8'h01; poll until bit1=1. bit0=1 → poll only.
  - RESUME: bit0=1 → write 8'h01; poll until bit1=0. bit0=0 → poll only.
  - STEP: needs bit0=1 and bit1=1, else DONE with error, no writes. count=0 → DONE, no error. Per step: write 8'h10, wait STEP_GAP cycles, poll until bit1=1, increment rsp_steps; repeat until rsp_steps==count.
  - RESET_CPU: write 8'h04; poll until bit2=0.
- Poll = repeated reads; every read updates rsp_status. Reaching POLL_LIMIT reads without the condition → DONE with error (rsp_steps keeps completed count).
- DONE: rsp_valid=1 for one cycle, then IDLE.
- New commands are never accepted while busy; cmd_valid is ignored until cmd_ready.

## Timing
- Reset: PSEL, PENABLE, PWRITE, PWDATA, cmd_ready, rsp_* all 0; state IDLE; cmd_ready=1 the first cycle after PRESET deasserts. PRESET mid-transfer aborts the transfer immediately (PSEL drops next edge), no rsp_valid.
- APB: SETUP (PSEL=1, PENABLE=0) one cycle; ACCESS (PSEL=1, PENABLE=1) held until PREADY; PADDR/PWRITE/PWDATA stable across both. PRDATA sampled on the ACCESS cycle with PREADY=1.
- Mandatory GAP: at least one cycle with PSEL=0 and PENABLE=0 after every transfer (slave detects PENABLE rising edge).
- Latency with PREADY=1: accept at edge N → SETUP cycle N+1, ACCESS N+2, GAP N+3, next SETUP N+4 (3 cycles/transfer).
- HALT already halted: accept N, read N+1..N+2, poll read N+4..N+5, rsp_valid at N+7.
- PWDATA=0 whenever PWRITE=0.

## Test plan
- Reset: hold PRESET 3 cycles mid-ACCESS → PSEL/PENABLE drop after the reset edge, all outputs 0, cmd_ready=1 after release, no rsp_valid.
- HALT from running (slave reads 8'h00, ACK rises 4 cycles after toggle) → exactly one write of 8'h01 with PENABLE low between transfers, rsp_valid, rsp_error=0, rsp_status bit1=1.
- HALT when already halted (8'h0B) → no write issued, rsp_valid at accept+7 with PREADY=1.
- STEP count=3 from halted model → three writes of 8'h10, each followed by ≥8 idle cycles, rsp_steps=3, rsp_error=0; STEP while running → rsp_error=1, zero writes.
- RESET_CPU, bit2 high 7 cycles → write 8'h04, polls until bit2=0, rsp_error=0; PREADY held low 5 cycles on one access → ACCESS extended, data unchanged.
- Timeout: POLL_LIMIT=4, HALT with ACK never rising → one write, 4 poll reads, rsp_valid with rsp_error=1.

Source files
------------

// File: rtl/debug_run_controller.sv
// Purpose: APB master that turns host debug commands (halt/resume/step/reset) into status-register read/write/poll sequences.
// Latency: 3 cycles per APB transfer with PREADY=1 (SETUP, ACCESS, GAP); HALT on an already halted core completes 7 cycles after accept.
// Backpressure: ACCESS is held while PREADY=0; cmd_ready is low whenever a command is in flight.
module debug_run_controller #(
    parameter logic [4:0]  STATUS_ADDR = 5'h00,
    parameter int unsigned POLL_LIMIT  = 255,
    parameter int unsigned STEP_GAP    = 8
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_count,
    output logic       rsp_valid,
    output logic       rsp_error,
    output logic [7:0] rsp_status,
    output logic [7:0] rsp_steps,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [4:0] PADDR,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_ACCESS, S_GAP, S_DECIDE, S_WAIT, S_DONE
    } state_t;

    // What the transfer currently on the bus is for; steers the decision made in GAP.
    typedef enum logic [1:0] {
        PH_READ, PH_WRITE, PH_POLL
    } phase_t;

    localparam logic [1:0] OP_HALT   = 2'd0;
    localparam logic [1:0] OP_RESUME = 2'd1;
    localparam logic [1:0] OP_STEP   = 2'd2;
    localparam logic [1:0] OP_RESET  = 2'd3;

    localparam logic [7:0] WR_TOGGLE = 8'h01;
    localparam logic [7:0] WR_RESET  = 8'h04;
    localparam logic [7:0] WR_STEP   = 8'h10;

    localparam logic [7:0] POLL_MAX = 8'(POLL_LIMIT);
    localparam logic [7:0] WAIT_END = 8'(STEP_GAP - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    phase_t     r_phase;
    logic [1:0] r_op;
    logic [7:0] r_count;
    logic [7:0] r_status;
    logic [7:0] r_steps;
    logic       r_err;
    logic       r_pwrite;
    logic [7:0] r_pwdata;
    logic [7:0] r_polls;
    logic [7:0] r_wait;

    logic       w_launch;
    logic       w_launch_wr;
    logic [7:0] w_launch_dat;
    phase_t     w_launch_ph;
    logic       w_step_inc;
    logic       w_set_err;
    logic       w_poll_met;
    logic       w_accept;
    logic       w_xfer_done;

    assign w_accept    = (r_state == S_IDLE) && cmd_valid;
    assign w_xfer_done = (r_state == S_ACCESS) && PREADY;

    // Completion condition of the poll phase for the command in flight.
    always_comb begin
        w_poll_met = 1'b0;
        case (r_op)
            OP_HALT:   w_poll_met = r_status[1];
            OP_RESUME: w_poll_met = !r_status[1];
            OP_STEP:   w_poll_met = r_status[1];
            OP_RESET:  w_poll_met = !r_status[2];
        endcase
    end

    // State register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the transfer to launch; decisions are taken in GAP so a transfer costs no extra cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_launch     = 1'b0;
        w_launch_wr  = 1'b0;
        w_launch_dat = 8'h00;
        w_launch_ph  = PH_READ;
        w_step_inc   = 1'b0;
        w_set_err    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_launch    = 1'b1;
                    w_launch_ph = PH_READ;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                if (PREADY) begin
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                case (r_phase)
                    PH_READ: begin
                        case (r_op)
                            OP_HALT, OP_RESUME: begin
                                w_launch    = 1'b1;
                                w_state_nxt = S_SETUP;
                                // Toggle only if the request bit is not already where we want it.
                                if (r_status[0] == (r_op == OP_RESUME)) begin
                                    w_launch_wr  = 1'b1;
                                    w_launch_dat = WR_TOGGLE;
                                    w_launch_ph  = PH_WRITE;
                                end else begin
                                    w_launch_ph  = PH_POLL;
                                end
                            end
                            OP_STEP: begin
                                if (!(r_status[0] && r_status[1])) begin
                                    w_set_err   = 1'b1;
                                    w_state_nxt = S_DONE;
                                end else if (r_count == 8'd0) begin
                                    w_state_nxt = S_DONE;
                                end else begin
                                    w_launch     = 1'b1;
                                    w_launch_wr  = 1'b1;
                                    w_launch_dat = WR_STEP;
                                    w_launch_ph  = PH_WRITE;
                                    w_state_nxt  = S_SETUP;
                                end
                            end
                            OP_RESET: begin
                                w_launch     = 1'b1;
                                w_launch_wr  = 1'b1;
                                w_launch_dat = WR_RESET;
                                w_launch_ph  = PH_WRITE;
                                w_state_nxt  = S_SETUP;
                            end
                        endcase
                    end
                    PH_WRITE: begin
                        if (r_op == OP_STEP) begin
                            w_state_nxt = S_WAIT;
                        end else begin
                            w_launch    = 1'b1;
                            w_launch_ph = PH_POLL;
                            w_state_nxt = S_SETUP;
                        end
                    end
                    PH_POLL: begin
                        if (w_poll_met) begin
                            w_state_nxt = (r_op == OP_STEP) ? S_DECIDE : S_DONE;
                        end else if (r_polls >= POLL_MAX) begin
                            w_set_err   = 1'b1;
                            w_state_nxt = S_DONE;
                        end else begin
                            w_launch    = 1'b1;
                            w_launch_ph = PH_POLL;
                            w_state_nxt = S_SETUP;
                        end
                    end
                    default: begin
                        w_state_nxt = S_IDLE;
                    end
                endcase
            end
            S_WAIT: begin
                // Let the step window run out before looking at ACK again.
                if (r_wait == WAIT_END) begin
                    w_launch    = 1'b1;
                    w_launch_ph = PH_POLL;
                    w_state_nxt = S_SETUP;
                end
            end
            S_DECIDE: begin
                w_step_inc = 1'b1;
                if ((r_steps + 8'd1) == r_count) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_launch     = 1'b1;
                    w_launch_wr  = 1'b1;
                    w_launch_dat = WR_STEP;
                    w_launch_ph  = PH_WRITE;
                    w_state_nxt  = S_SETUP;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Command latch, APB transfer registers, captured status and step/poll bookkeeping.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_op     <= 2'd0;
            r_count  <= 8'd0;
            r_status <= 8'd0;
            r_steps  <= 8'd0;
            r_err    <= 1'b0;
            r_phase  <= PH_READ;
            r_pwrite <= 1'b0;
            r_pwdata <= 8'd0;
            r_polls  <= 8'd0;
            r_wait   <= 8'd0;
        end else begin
            if (w_accept) begin
                r_op     <= cmd_op;
                r_count  <= cmd_count;
                r_status <= 8'd0;
                r_steps  <= 8'd0;
                r_err    <= 1'b0;
            end
            if (w_launch) begin
                r_pwrite <= w_launch_wr;
                r_pwdata <= w_launch_dat;
                r_phase  <= w_launch_ph;
                // Poll budget restarts each time a fresh poll phase begins.
                if ((w_launch_ph == PH_POLL) && (r_phase != PH_POLL)) begin
                    r_polls <= 8'd0;
                end
            end
            if (w_xfer_done) begin
                // Write strobes are dropped so PWDATA reads as zero outside writes.
                r_pwrite <= 1'b0;
                r_pwdata <= 8'd0;
                if (!r_pwrite) begin
                    r_status <= PRDATA;
                end
                if (r_phase == PH_POLL) begin
                    r_polls <= r_polls + 8'd1;
                end
            end
            if (r_state == S_WAIT) begin
                r_wait <= r_wait + 8'd1;
            end else begin
                r_wait <= 8'd0;
            end
            if (w_step_inc) begin
                r_steps <= r_steps + 8'd1;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign PSEL       = (r_state == S_SETUP) || (r_state == S_ACCESS);
    assign PENABLE    = (r_state == S_ACCESS);
    assign PWRITE     = r_pwrite;
    assign PWDATA     = r_pwdata;
    assign PADDR      = STATUS_ADDR;
    assign cmd_ready  = (r_state == S_IDLE) && !PRESET;
    assign rsp_valid  = (r_state == S_DONE);
    assign rsp_error  = (r_state == S_DONE) && r_err;
    assign rsp_status = r_status;
    assign rsp_steps  = r_steps;

endmodule
